spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Output-side counterpart of the input_neuron encoders. Where input_neuron turns sensor levels into spike trains, this block turns the two excitatory-neuron spike trains (Left, Right) back into motor commands. It counts spikes per channel over a fixed window of clock cycles and classifies the rate pair into a 2-bit steering command. The command is delivered through a valid/ready handshake to the motor controller. It sits directly after the exc_neuron outputs in the SNN top level.

Parameters:
WINDOW, 16, window length in clk cycles (>=2)
CNT_W, 8, spike counter / rate output width; counters saturate at 2^CNT_W-1
DIFF_TH, 3, minimum rate difference (spikes per window) that selects a turn
MIN_SPIKES, 2, minimum total spikes per window to leave STOP

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  decode enable; counting runs only while high
spike_left  input  1  Output_spike of Left exc_neuron, sampled each clk
spike_right  input  1  Output_spike of Right exc_neuron, sampled each clk
cmd_ready  input  1  consumer ready
cmd_valid  output  1  command available
cmd  output  2  00 STOP, 01 TURN_LEFT, 10 TURN_RIGHT, 11 FORWARD
rate_left  output  CNT_W  left spike count of the reported window
rate_right  output  CNT_W  right spike count of the reported window
overrun  output  1  sticky flag: an unaccepted command was overwritten

Behaviour:
- Reset (rst=0, async): state=IDLE; win_cnt, cnt_l, cnt_r, cmd_valid, cmd, rate_left, rate_right and overrun are all 0. Reset mid-window discards the partial counts.
- States: IDLE, COUNT.
  - IDLE -> COUNT on the first cycle with en=1. That cycle is window cycle 0, and its spikes are counted.
  - COUNT -> IDLE whenever en=0. This clears win_cnt, cnt_l and cnt_r. The output register and handshake state are untouched.
- In COUNT, each cycle: cnt_l += spike_left and cnt_r += spike_right, both saturating at 2^CNT_W-1. win_cnt increments.
- On window cycle WINDOW-1 (its spikes included), at the next edge:
  - final counts load into rate_left/rate_right;
  - cmd is computed from the final counts;
  - cmd_valid is set;
  - win_cnt, cnt_l and cnt_r restart at 0 with no dead cycle. The following cycle is window cycle 0 and its spikes are counted.
- Latency: cmd_valid is visible in cycle WINDOW counted from the first en cycle (cycle 0).
- Classification: comparisons are unsigned, at width CNT_W+1 (no overflow). With L and R the final counts:
  - L+R < MIN_SPIKES -> 00 (STOP);
  - else L >= R+DIFF_TH -> 01 (TURN_LEFT);
  - else R >= L+DIFF_TH -> 10 (TURN_RIGHT);
  - else 11 (FORWARD).
- Handshake:
  - Transfer occurs on any cycle with cmd_valid=1 and cmd_ready=1.
  - cmd, rate_left and rate_right are stable while cmd_valid=1 and no transfer occurs, except on overwrite.
  - cmd_valid clears after a transfer unless a new result loads on the same edge.
- Simultaneous events:
  - New result and transfer on the same edge: load new data, cmd_valid stays 1, overrun unchanged.
  - New result while cmd_valid=1 and no transfer: new data overwrites, overrun <= 1.
- overrun clears only on reset.
- en=0 does not drop a pending command; the handshake continues.

Test Plan:
- Reset: assert rst=0 mid-run with cmd_valid=1 and cnt_l=7 -> all outputs read 0 immediately (asynchronously). After release with en=1, the first cmd_valid appears at cycle 16.
- spike_left=1 every cycle, spike_right=0, en=1, cmd_ready=1, defaults -> cycle 16: cmd_valid=1, cmd=01, rate_left=16, rate_right=0. cmd_valid drops at cycle 17.
- Window boundary and classification, with counts injected per window (spike on window cycle 15 included):
  - L=6, R=3 -> cmd=01;
  - L=5, R=3 -> cmd=11;
  - L=2, R=9 -> cmd=10;
  - L=1, R=0 -> cmd=00.
  - Back-to-back windows must lose no spikes.
- Backpressure: cmd_ready=0 for two windows (L=16,R=0 then L=0,R=16) -> overrun=1; cmd=10 and rate_right=16 hold until cmd_ready=1. Then transfer, cmd_valid=0, overrun stays 1.
- en dropped at window cycle 8 after 8 left spikes, re-raised 3 cycles later with no spikes -> the next result has rate_left=0 and arrives 16 cycles after re-enable.
- CNT_W=4, WINDOW=32, both spikes every cycle -> rate_left=rate_right=15 (saturated), cmd=11.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Turns the Left/Right excitatory-neuron spike trains back into a steering
//   command. Spikes on each channel are counted over a window of WINDOW
//   enabled clock cycles. At the end of each window the two counts are
//   classified into a 2-bit command, which is then offered to the motor
//   controller over a valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low (0 = reset)
//   en           decode enable; counting runs only while high
//   spike_left   Left exc_neuron output spike, sampled every clk
//   spike_right  Right exc_neuron output spike, sampled every clk
//   cmd_ready    consumer ready
//   cmd_valid    command available
//   cmd          00 STOP, 01 TURN_LEFT, 10 TURN_RIGHT, 11 FORWARD
//   rate_left    left spike count of the reported window
//   rate_right   right spike count of the reported window
//   overrun      sticky: a command nobody accepted was overwritten
module spike_rate_decoder #(
  parameter int WINDOW     = 16,
  parameter int CNT_W      = 8,
  parameter int DIFF_TH    = 3,
  parameter int MIN_SPIKES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_left,
  input  logic             spike_right,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd,
  output logic [CNT_W-1:0] rate_left,
  output logic [CNT_W-1:0] rate_right,
  output logic             overrun
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [1:0] CMD_STOP    = 2'b00;
  localparam logic [1:0] CMD_LEFT    = 2'b01;
  localparam logic [1:0] CMD_RIGHT   = 2'b10;
  localparam logic [1:0] CMD_FORWARD = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] cnt_l_q, cnt_l_d;
  logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] rate_left_q, rate_left_d;
  logic [CNT_W-1:0] rate_right_q, rate_right_d;
  logic             overrun_q, overrun_d;

  logic [CNT_W-1:0] next_l, next_r;
  logic             last_cycle, load, xfer;

  // Saturating +1: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             s);
    if (s && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
    return c;
  endfunction

  // Rate-pair classification, done one bit wider than the counts so the
  // sums cannot overflow.
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] l_in,
                                          input logic [CNT_W-1:0] r_in);
    logic [CNT_W:0] l, r;
    l = {1'b0, l_in};
    r = {1'b0, r_in};
    if ((l + r) < (CNT_W+1)'(MIN_SPIKES))      return CMD_STOP;
    if (l >= (r + (CNT_W+1)'(DIFF_TH)))        return CMD_LEFT;
    if (r >= (l + (CNT_W+1)'(DIFF_TH)))        return CMD_RIGHT;
    return CMD_FORWARD;
  endfunction

  // The IDLE cycle that sees en=1 is already window cycle 0, so counting
  // depends only on en. Counters are held at zero while IDLE.
  assign next_l     = sat_inc(cnt_l_q, spike_left);
  assign next_r     = sat_inc(cnt_r_q, spike_right);
  assign last_cycle = (win_cnt_q == WIN_W'(WINDOW - 1));
  assign load       = en && last_cycle;
  assign xfer       = cmd_valid_q && cmd_ready;

  // Control state machine
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en)  state_d = S_COUNT;
      S_COUNT: if (!en) state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  // Window counters and output/handshake register
  always_comb begin
    win_cnt_d    = win_cnt_q;
    cnt_l_d      = cnt_l_q;
    cnt_r_d      = cnt_r_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_d        = cmd_q;
    rate_left_d  = rate_left_q;
    rate_right_d = rate_right_q;
    overrun_d    = overrun_q;

    if (!en) begin
      // Leaving the window discards partial counts; a pending command stays.
      win_cnt_d = '0;
      cnt_l_d   = '0;
      cnt_r_d   = '0;
    end else if (last_cycle) begin
      // Restart immediately so the next cycle is window cycle 0.
      win_cnt_d = '0;
      cnt_l_d   = '0;
      cnt_r_d   = '0;
    end else begin
      win_cnt_d = win_cnt_q + 1'b1;
      cnt_l_d   = next_l;
      cnt_r_d   = next_r;
    end

    if (xfer) cmd_valid_d = 1'b0;

    if (load) begin
      rate_left_d  = next_l;
      rate_right_d = next_r;
      cmd_d        = classify(next_l, next_r);
      cmd_valid_d  = 1'b1;
      if (cmd_valid_q && !xfer) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      win_cnt_q    <= '0;
      cnt_l_q      <= '0;
      cnt_r_q      <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= CMD_STOP;
      rate_left_q  <= '0;
      rate_right_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      cnt_l_q      <= cnt_l_d;
      cnt_r_q      <= cnt_r_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      rate_left_q  <= rate_left_d;
      rate_right_q <= rate_right_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd        = cmd_q;
  assign rate_left  = rate_left_q;
  assign rate_right = rate_right_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, spike_left, spike_right, cmd_ready;
  logic       cmd_valid, overrun;
  logic [1:0] cmd;
  logic [7:0] rate_left, rate_right;

  logic       en2, sl2, sr2, ready2;
  logic       cmd_valid2, overrun2;
  logic [1:0] cmd2;
  logic [3:0] rate_left2, rate_right2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_rate_decoder dut (
    .clk(clk), .rst(rst), .en(en),
    .spike_left(spike_left), .spike_right(spike_right),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd(cmd),
    .rate_left(rate_left), .rate_right(rate_right), .overrun(overrun)
  );

  spike_rate_decoder #(.WINDOW(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en2),
    .spike_left(sl2), .spike_right(sr2),
    .cmd_ready(ready2), .cmd_valid(cmd_valid2), .cmd(cmd2),
    .rate_left(rate_left2), .rate_right(rate_right2), .overrun(overrun2)
  );

  typedef struct {
    int         l;
    int         r;
    logic [1:0] cmd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-cycle window: left spikes packed at the end (touching cycle 15),
  // right spikes packed at the start (touching cycle 0).
  task automatic run_window(input int l, input int r);
    for (int i = 0; i < 16; i++) begin
      spike_left  = (i >= 16 - l);
      spike_right = (i < r);
      tick();
    end
    spike_left  = 1'b0;
    spike_right = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{6, 3, 2'b01};
    tbl[1]  = '{5, 3, 2'b11};
    tbl[2]  = '{2, 9, 2'b10};
    tbl[3]  = '{1, 0, 2'b00};
    tbl[4]  = '{16, 0, 2'b01};
    tbl[5]  = '{0, 0, 2'b00};
    tbl[6]  = '{3, 0, 2'b01};
    tbl[7]  = '{0, 16, 2'b10};
    tbl[8]  = '{8, 8, 2'b11};
    tbl[9]  = '{0, 2, 2'b11};
    tbl[10] = '{0, 1, 2'b00};
    tbl[11] = '{4, 7, 2'b10};

    rst = 1'b0; en = 1'b0; spike_left = 1'b0; spike_right = 1'b0; cmd_ready = 1'b1;
    en2 = 1'b0; sl2 = 1'b0; sr2 = 1'b0; ready2 = 1'b1;
    #22;
    chk("reset_valid", cmd_valid, 0);
    chk("reset_cmd", cmd, 0);
    chk("reset_rate_l", rate_left, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b1;

    // Left every cycle: first result in cycle 16, accepted immediately.
    en = 1'b1; spike_left = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("lat_not_early", cmd_valid, 0);
    tick();
    chk("lat_valid", cmd_valid, 1);
    chk("lat_cmd", cmd, 1);
    chk("lat_rate_l", rate_left, 16);
    chk("lat_rate_r", rate_right, 0);
    tick();
    chk("lat_drop", cmd_valid, 0);
    en = 1'b0; spike_left = 1'b0;
    tick();

    // Back-to-back windows from the table.
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      run_window(tbl[k].l, tbl[k].r);
      chk($sformatf("tbl%0d_valid", k), cmd_valid, 1);
      chk($sformatf("tbl%0d_cmd", k), cmd, tbl[k].cmd);
      chk($sformatf("tbl%0d_rate_l", k), rate_left, tbl[k].l);
      chk($sformatf("tbl%0d_rate_r", k), rate_right, tbl[k].r);
    end
    en = 1'b0;
    tick();
    chk("tbl_end_valid", cmd_valid, 0);
    chk("tbl_end_overrun", overrun, 0);

    // Backpressure across two windows.
    cmd_ready = 1'b0; en = 1'b1;
    run_window(16, 0);
    chk("bp1_valid", cmd_valid, 1);
    chk("bp1_cmd", cmd, 1);
    chk("bp1_overrun", overrun, 0);
    run_window(0, 16);
    chk("bp2_cmd", cmd, 2);
    chk("bp2_rate_r", rate_right, 16);
    chk("bp2_rate_l", rate_left, 0);
    chk("bp2_overrun", overrun, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_hold_valid", cmd_valid, 1);
    chk("bp_hold_cmd", cmd, 2);
    chk("bp_hold_rate_r", rate_right, 16);
    cmd_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", cmd_valid, 0);
    chk("bp_sticky_overrun", overrun, 1);

    // en dropped mid-window: partial counts are lost.
    en = 1'b1; spike_left = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    en = 1'b1; spike_left = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("endrop_not_early", cmd_valid, 0);
    tick();
    chk("endrop_valid", cmd_valid, 1);
    chk("endrop_rate_l", rate_left, 0);
    chk("endrop_cmd", cmd, 0);

    // Asynchronous reset with a pending command and a partial count of 7.
    cmd_ready = 1'b0;
    run_window(5, 0);
    chk("prerst_valid", cmd_valid, 1);
    chk("prerst_rate_l", rate_left, 5);
    spike_left = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b0;
    #1;
    chk("arst_valid", cmd_valid, 0);
    chk("arst_cmd", cmd, 0);
    chk("arst_rate_l", rate_left, 0);
    chk("arst_rate_r", rate_right, 0);
    chk("arst_overrun", overrun, 0);
    #2;
    rst = 1'b1; en = 1'b1; cmd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      spike_left = (i < 2);
      if (i == 15) chk("post_rst_not_early", cmd_valid, 0);
      tick();
    end
    chk("post_rst_valid", cmd_valid, 1);
    chk("post_rst_rate_l", rate_left, 2);
    chk("post_rst_cmd", cmd, 3);
    en = 1'b0; spike_left = 1'b0;

    // Saturating counters: CNT_W=4, WINDOW=32, both channels always firing.
    en2 = 1'b1; sl2 = 1'b1; sr2 = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    chk("sat_not_early", cmd_valid2, 0);
    tick();
    chk("sat_valid", cmd_valid2, 1);
    chk("sat_rate_l", rate_left2, 15);
    chk("sat_rate_r", rate_right2, 15);
    chk("sat_cmd", cmd2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
